// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: counter encodings and table geometry helpers.
package branch_predictor_pkg;

  // 2-bit direction counter; the MSB is the taken/not-taken prediction.
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  // Number of index bits for a table of the given depth.
  function automatic int idx_width(input int entries);
    return $clog2(entries);
  endfunction

  // Tag covers every PC bit above the index and the word-offset bits.
  function automatic int tag_width(input int xlen, input int entries);
    return xlen - $clog2(entries) - 2;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state logic of a 2-bit saturating direction counter.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  ctr_e ctr_cur,
  input  logic taken,
  output ctr_e ctr_next
);

  // Step one position toward the resolved direction, holding at the ends.
  always_comb begin
    ctr_next = ctr_cur;
    unique case (ctr_cur)
      CTR_SNT: ctr_next = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: ctr_next = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  ctr_next = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  ctr_next = taken ? CTR_ST  : CTR_WT;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Bimodal indexing when GHR_BITS=0, gshare (history XOR low index bits) otherwise.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 64,
  parameter int GHR_BITS = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_if,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_uncond,
  input  logic            upd_mispred,
  output logic [31:0]     perf_lookups,
  output logic [31:0]     perf_mispred
);

  localparam int IDX   = idx_width(ENTRIES);
  localparam int TAGW  = tag_width(XLEN, ENTRIES);
  // Keep a 1-bit history register in bimodal mode so the declarations stay legal;
  // it is never shifted and so stays zero.
  localparam int GHR_W = (GHR_BITS == 0) ? 1 : GHR_BITS;

  logic            valid_q  [ENTRIES];
  logic [TAGW-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0] target_q [ENTRIES];
  logic            uncond_q [ENTRIES];
  ctr_e            ctr_q    [ENTRIES];

  logic            valid_d  [ENTRIES];
  logic [TAGW-1:0] tag_d    [ENTRIES];
  logic [XLEN-1:0] target_d [ENTRIES];
  logic            uncond_d [ENTRIES];
  ctr_e            ctr_d    [ENTRIES];

  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [31:0]      perf_lookups_q, perf_lookups_d;
  logic [31:0]      perf_mispred_q, perf_mispred_d;

  logic [IDX-1:0]  ghr_idx;
  logic [IDX-1:0]  lk_idx, upd_idx;
  logic [TAGW-1:0] lk_tag, upd_tag;
  logic            lk_hit, upd_hit;
  ctr_e            upd_ctr_next;

  // Word-offset bits never take part in indexing or tagging.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{pc_if[1:0], upd_pc[1:0]};

  // Index and tag extraction for both ports; both use the current (pre-shift) history.
  always_comb begin
    ghr_idx = IDX'(ghr_q);
    lk_idx  = pc_if[IDX+1:2] ^ ghr_idx;
    upd_idx = upd_pc[IDX+1:2] ^ ghr_idx;
    lk_tag  = pc_if[XLEN-1:IDX+2];
    upd_tag = upd_pc[XLEN-1:IDX+2];
    lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  end

  // Zero-latency lookup from the registered table; same-cycle updates are not bypassed.
  always_comb begin
    pred_taken  = lk_hit && (uncond_q[lk_idx] || ctr_q[lk_idx][1]);
    pred_target = pred_taken ? target_q[lk_idx] : (pc_if + XLEN'(32'd4));
  end

  sat_counter2 u_sat_counter2 (
    .ctr_cur  (ctr_q[upd_idx]),
    .taken    (upd_taken),
    .ctr_next (upd_ctr_next)
  );

  // Table, history and performance-counter next state from the resolved branch.
  always_comb begin
    valid_d        = valid_q;
    tag_d          = tag_q;
    target_d       = target_q;
    uncond_d       = uncond_q;
    ctr_d          = ctr_q;
    ghr_d          = ghr_q;
    perf_lookups_d = perf_lookups_q;
    perf_mispred_d = perf_mispred_q;
    if (upd_valid) begin
      if (upd_hit) begin
        ctr_d[upd_idx]    = upd_ctr_next;
        target_d[upd_idx] = upd_target;
        uncond_d[upd_idx] = upd_uncond;
      end else if (upd_taken) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target;
        uncond_d[upd_idx] = upd_uncond;
        ctr_d[upd_idx]    = CTR_WT;
      end
      if ((GHR_BITS > 0) && !upd_uncond) begin
        ghr_d = GHR_W'({ghr_q, upd_taken});
      end
      perf_lookups_d = perf_lookups_q + 32'd1;
      if (upd_mispred) begin
        perf_mispred_d = perf_mispred_q + 32'd1;
      end
    end
  end

  // State registers; reset wins over a coincident update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        uncond_q[i] <= 1'b0;
        ctr_q[i]    <= CTR_WNT;
      end
      ghr_q          <= '0;
      perf_lookups_q <= '0;
      perf_mispred_q <= '0;
    end else begin
      valid_q        <= valid_d;
      tag_q          <= tag_d;
      target_q       <= target_d;
      uncond_q       <= uncond_d;
      ctr_q          <= ctr_d;
      ghr_q          <= ghr_d;
      perf_lookups_q <= perf_lookups_d;
      perf_mispred_q <= perf_mispred_d;
    end
  end

  assign perf_lookups = perf_lookups_q;
  assign perf_mispred = perf_mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (bimodal, 64 entries) with a scoreboard queue.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] pc_if;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_uncond;
  logic        upd_mispred;
  logic [31:0] perf_lookups;
  logic [31:0] perf_mispred;

  typedef struct {
    string       name;
    bit          is_perf;
    logic        taken;
    logic [31:0] target;
    logic [31:0] lookups;
    logic [31:0] mispred;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  branch_predictor #(
    .XLEN     (32),
    .ENTRIES  (64),
    .GHR_BITS (0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_if        (pc_if),
    .pred_taken   (pred_taken),
    .pred_target  (pred_target),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target),
    .upd_uncond   (upd_uncond),
    .upd_mispred  (upd_mispred),
    .perf_lookups (perf_lookups),
    .perf_mispred (perf_mispred)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: the lookup is combinational, so the DUT presents a result every cycle;
  // sample at the falling edge and retire whatever the stimulus queued for this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      if (e.is_perf) begin
        if (perf_lookups !== e.lookups || perf_mispred !== e.mispred) begin
          n_fail++;
          $display("FAIL %s: got lookups=%0d mispred=%0d, want lookups=%0d mispred=%0d",
                   e.name, perf_lookups, perf_mispred, e.lookups, e.mispred);
        end
      end else begin
        if (pred_taken !== e.taken || pred_target !== e.target) begin
          n_fail++;
          $display("FAIL %s: got taken=%0b target=0x%08h, want taken=%0b target=0x%08h",
                   e.name, pred_taken, pred_target, e.taken, e.target);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    upd_valid   = 1'b0;
    upd_taken   = 1'b0;
    upd_uncond  = 1'b0;
    upd_mispred = 1'b0;
  endtask

  task automatic exp_pred(input string name, input logic t, input logic [31:0] tgt);
    exp_t e;
    e.name = name; e.is_perf = 1'b0; e.taken = t; e.target = tgt;
    e.lookups = '0; e.mispred = '0;
    sb.push_back(e);
  endtask

  task automatic exp_perf(input string name, input logic [31:0] lk, input logic [31:0] mp);
    exp_t e;
    e.name = name; e.is_perf = 1'b1; e.taken = 1'b0; e.target = '0;
    e.lookups = lk; e.mispred = mp;
    sb.push_back(e);
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                     input logic unc, input logic mp);
    upd_valid   = 1'b1;
    upd_pc      = pc;
    upd_taken   = t;
    upd_target  = tgt;
    upd_uncond  = unc;
    upd_mispred = mp;
  endtask

  initial begin
    rst = 1'b1; pc_if = 32'h0; upd_valid = 1'b0; upd_pc = 32'h0;
    upd_taken = 1'b0; upd_target = 32'h0; upd_uncond = 1'b0; upd_mispred = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // C1: cold lookup right after reset
    pc_if = 32'h40;
    exp_pred("cold_lookup", 1'b0, 32'h44);
    exp_perf("reset_perf", 32'd0, 32'd0);
    next_cycle();
    // C2: allocate 0x40 -> 0x100; the same-cycle lookup still sees the empty entry
    pc_if = 32'h40; upd(32'h40, 1'b1, 32'h100, 1'b0, 1'b1);
    exp_pred("alloc_same_cycle_old", 1'b0, 32'h44);
    next_cycle();
    // C3: allocated entry predicts taken (ctr=10)
    pc_if = 32'h40;
    exp_pred("alloc_hit", 1'b1, 32'h100);
    exp_perf("perf_after_alloc", 32'd1, 32'd1);
    next_cycle();
    // C4: 0x140 shares the index of 0x40 but not the tag
    pc_if = 32'h140;
    exp_pred("alias_tag_miss", 1'b0, 32'h144);
    next_cycle();
    // C5: first not-taken update; this cycle still returns the old taken prediction
    pc_if = 32'h40; upd(32'h40, 1'b0, 32'h100, 1'b0, 1'b1);
    exp_pred("same_cycle_old_pred", 1'b1, 32'h100);
    next_cycle();
    // C6: ctr=01 now predicts not taken; second not-taken update -> 00
    pc_if = 32'h40; upd(32'h40, 1'b0, 32'h100, 1'b0, 1'b0);
    exp_pred("hyst_ctr01", 1'b0, 32'h44);
    next_cycle();
    // C7: third not-taken update must hold ctr at 00
    pc_if = 32'h40; upd(32'h40, 1'b0, 32'h100, 1'b0, 1'b0);
    exp_pred("hyst_ctr00", 1'b0, 32'h44);
    next_cycle();
    // C8: taken update: 00 -> 01 (a wrap to 11 would make the next lookup taken)
    pc_if = 32'h40; upd(32'h40, 1'b1, 32'h100, 1'b0, 1'b1);
    exp_pred("sat_low_pre", 1'b0, 32'h44);
    next_cycle();
    // C9: ctr=01 still not taken; another taken update -> 10
    pc_if = 32'h40; upd(32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
    exp_pred("sat_low_hold", 1'b0, 32'h44);
    next_cycle();
    // C10: ctr=10 taken again; allocate an unconditional jump at 0x80
    pc_if = 32'h40; upd(32'h80, 1'b1, 32'h200, 1'b1, 1'b1);
    exp_pred("retrain_taken", 1'b1, 32'h100);
    exp_perf("perf_mid", 32'd6, 32'd3);
    next_cycle();
    // C11: jump predicted; drive its counter down to 01 while keeping uncond set
    pc_if = 32'h80; upd(32'h80, 1'b0, 32'h200, 1'b1, 1'b0);
    exp_pred("uncond_alloc", 1'b1, 32'h200);
    next_cycle();
    // C12: uncond overrides a weak counter; not-taken miss at 0xC0 must not allocate
    pc_if = 32'h80; upd(32'hC0, 1'b0, 32'h300, 1'b0, 1'b0);
    exp_pred("uncond_override", 1'b1, 32'h200);
    next_cycle();
    // C13: 0xC0 still absent; one more mispredicted update brings mispred to 5
    pc_if = 32'hC0; upd(32'hC0, 1'b0, 32'h300, 1'b0, 1'b1);
    exp_pred("nt_miss_no_alloc", 1'b0, 32'hC4);
    next_cycle();
    // C14: update fields driven with upd_valid=0 must be ignored
    pc_if = 32'h40;
    upd_pc = 32'h40; upd_taken = 1'b0; upd_target = 32'h999; upd_mispred = 1'b1;
    exp_pred("pre_idle_upd", 1'b1, 32'h100);
    exp_perf("perf_before_rst", 32'd10, 32'd5);
    next_cycle();
    // C15: reset together with an update
    pc_if = 32'h40; rst = 1'b1; upd(32'h100, 1'b1, 32'h300, 1'b0, 1'b1);
    exp_pred("idle_upd_ignored", 1'b1, 32'h100);
    next_cycle();
    rst = 1'b0;
    // C16: table and counters cleared
    pc_if = 32'h40;
    exp_pred("rst_table_empty", 1'b0, 32'h44);
    exp_perf("rst_perf_clear", 32'd0, 32'd0);
    next_cycle();
    // C17: the update issued with reset was dropped
    pc_if = 32'h100;
    exp_pred("rst_upd_dropped", 1'b0, 32'h104);
    next_cycle();

    @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
